// File: rtl/burst_replay_acc.sv
// -----------------------------------------------------------------------------
// burst_replay_acc
//
// Captures a burst of unsigned samples while IN_VALID is high, then replays
// the stored samples on OUT (forward or reverse) and ends with one reduction
// result (sum, max or min). The whole output train is count+1 consecutive
// OUT_VALID cycles.
//
// Parameters
//   DATA_W : sample width in bits
//   DEPTH  : maximum number of stored samples per burst (>= 1)
//   OUT_W  : output width, at least DATA_W + ceil(log2(DEPTH)) so that the
//            sum of a full burst never wraps
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST       in   synchronous active-high reset
//   IN_VALID  in   one sample beat per cycle while high (contiguous burst)
//   INPUT     in   sample, valid when IN_VALID = 1
//   MODE      in   0 fwd+sum, 1 rev+sum, 2 fwd+max, 3 fwd+min (first beat only)
//   OUT       out  replayed sample (zero-extended) or reduction result
//   OUT_VALID out  high while OUT carries replay or result data
//   OVF       out  high on the result beat when the burst exceeded DEPTH
//   BUSY      out  high while collecting (READ) or replaying (OUTPUT)
// -----------------------------------------------------------------------------
module burst_replay_acc #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 8,
  parameter int OUT_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] INPUT,
  input  logic [1:0]        MODE,
  output logic [OUT_W-1:0]  OUT,
  output logic              OUT_VALID,
  output logic              OVF,
  output logic              BUSY
);

  // count must be able to hold DEPTH itself (saturated full burst)
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_FWD_SUM = 2'd0;
  localparam logic [1:0] MODE_REV_SUM = 2'd1;
  localparam logic [1:0] MODE_FWD_MAX = 2'd2;
  localparam logic [1:0] MODE_FWD_MIN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t             state_reg,     state_next;
  logic [CNT_W-1:0]   count_reg,     count_next;
  logic [CNT_W-1:0]   rep_reg,       rep_next;
  logic [1:0]         mode_reg,      mode_next;
  logic [OUT_W-1:0]   acc_reg,       acc_next;
  logic               ovf_flag_reg,  ovf_flag_next;
  logic [OUT_W-1:0]   out_reg,       out_next;
  logic               out_valid_reg, out_valid_next;
  logic               ovf_reg,       ovf_next;
  logic               busy_reg,      busy_next;

  // sample storage, intentionally not reset
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               mem_wr_en;
  logic [AW-1:0]      mem_wr_addr;
  logic [AW-1:0]      mem_rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [CNT_W-1:0]   rd_idx;
  logic [OUT_W-1:0]   sample_ext;

  assign sample_ext = OUT_W'(INPUT);

  // Running reduction step; both sum modes share the adder.
  function automatic logic [OUT_W-1:0] acc_update(
    input logic [1:0]       m,
    input logic [OUT_W-1:0] a,
    input logic [OUT_W-1:0] s
  );
    logic [OUT_W-1:0] r;
    case (m)
      MODE_FWD_MAX: r = (s > a) ? s : a;
      MODE_FWD_MIN: r = (s < a) ? s : a;
      default:      r = a + s;
    endcase
    return r;
  endfunction

  // Replay position k: the READ->OUTPUT edge emits k=0, each OUTPUT edge
  // emits k=rep_reg. Reverse mode walks from slot count-1 down to slot 0.
  always_comb begin
    rd_idx = (state_reg == S_OUTPUT) ? rep_reg : '0;
    if (mode_reg == MODE_REV_SUM) begin
      mem_rd_addr = AW'(count_reg - CNT_W'(1) - rd_idx);
    end else begin
      mem_rd_addr = AW'(rd_idx);
    end
  end

  assign rd_data = mem[mem_rd_addr];

  // Next-state and output logic
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    rep_next       = rep_reg;
    mode_next      = mode_reg;
    acc_next       = acc_reg;
    ovf_flag_next  = ovf_flag_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    ovf_next       = 1'b0;
    mem_wr_en      = 1'b0;
    mem_wr_addr    = AW'(count_reg);

    case (state_reg)
      S_IDLE: begin
        out_next       = '0;
        out_valid_next = 1'b0;
        if (IN_VALID) begin
          mem_wr_en     = 1'b1;
          mem_wr_addr   = '0;
          count_next    = CNT_W'(1);
          mode_next     = MODE;
          acc_next      = sample_ext;
          ovf_flag_next = 1'b0;
          state_next    = S_READ;
        end
      end

      S_READ: begin
        if (IN_VALID) begin
          if (count_reg < CNT_W'(DEPTH)) begin
            mem_wr_en  = 1'b1;
            count_next = count_reg + CNT_W'(1);
            acc_next   = acc_update(mode_reg, acc_reg, sample_ext);
          end else begin
            // burst longer than storage: drop the beat, remember it
            ovf_flag_next = 1'b1;
          end
        end else begin
          state_next     = S_OUTPUT;
          out_next       = OUT_W'(rd_data);
          out_valid_next = 1'b1;
          rep_next       = CNT_W'(1);
        end
      end

      S_OUTPUT: begin
        out_valid_next = 1'b1;
        if (rep_reg < count_reg) begin
          out_next = OUT_W'(rd_data);
          rep_next = rep_reg + CNT_W'(1);
        end else begin
          // result beat; state is IDLE while it is on OUT so a new burst
          // can start on the very next edge
          out_next   = acc_reg;
          ovf_next   = ovf_flag_reg;
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      rep_reg       <= '0;
      mode_reg      <= MODE_FWD_SUM;
      acc_reg       <= '0;
      ovf_flag_reg  <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      rep_reg       <= rep_next;
      mode_reg      <= mode_next;
      acc_reg       <= acc_next;
      ovf_flag_reg  <= ovf_flag_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      ovf_reg       <= ovf_next;
      busy_reg      <= busy_next;
    end
  end

  // Storage write port
  always_ff @(posedge CLK) begin
    if (mem_wr_en && !RST) begin
      mem[mem_wr_addr] <= INPUT;
    end
  end

  assign OUT       = out_reg;
  assign OUT_VALID = out_valid_reg;
  assign OVF       = ovf_reg;
  assign BUSY      = busy_reg;

endmodule

// File: tb/tb_burst_replay_acc.sv
// -----------------------------------------------------------------------------
// tb_burst_replay_acc
//
// Drives directed bursts and then a random IN_VALID/INPUT/MODE/RST stream.
// A transaction-level model keeps the stored burst in a queue and, when the
// burst ends, queues the whole expected output train (replay beats then the
// reduction result); every cycle the DUT outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_burst_replay_acc;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 8;
  localparam int OUT_W  = 6;

  logic              CLK;
  logic              RST;
  logic              IN_VALID;
  logic [DATA_W-1:0] INPUT;
  logic [1:0]        MODE;
  logic [OUT_W-1:0]  OUT;
  logic              OUT_VALID;
  logic              OVF;
  logic              BUSY;

  burst_replay_acc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OUT_W  (OUT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .INPUT     (INPUT),
    .MODE      (MODE),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OVF       (OVF),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int          exp_q[$];
  bit          exp_ovf_q[$];
  bit          exp_res_q[$];
  int          stored[$];
  bit          collecting = 0;
  int          beats = 0;
  int          bmode = 0;
  bit          cur_valid = 0;
  int          cur_out = 0;
  bit          cur_ovf = 0;
  bit          cur_result = 0;
  bit          exp_busy = 0;

  int          stim_q[$];
  int          seen_q[$];
  int          ref_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // End of burst: queue replay beats and the reduction result.
  task automatic finish_burst();
    int sum, mx, mn, r;
    sum = 0;
    mx  = 0;
    mn  = (1 << DATA_W) - 1;
    for (int i = 0; i < stored.size(); i++) begin
      exp_q.push_back((bmode == 1) ? stored[stored.size() - 1 - i] : stored[i]);
      exp_ovf_q.push_back(1'b0);
      exp_res_q.push_back(1'b0);
      sum += stored[i];
      if (stored[i] > mx) mx = stored[i];
      if (stored[i] < mn) mn = stored[i];
    end
    case (bmode)
      2:       r = mx;
      3:       r = mn;
      default: r = sum % (1 << OUT_W);
    endcase
    exp_q.push_back(r);
    exp_ovf_q.push_back(beats > DEPTH);
    exp_res_q.push_back(1'b1);
  endtask

  // What one rising edge does to the burst/replay picture.
  task automatic model_edge(input bit rst, input bit iv, input int d, input int m);
    if (rst) begin
      exp_q.delete();
      exp_ovf_q.delete();
      exp_res_q.delete();
      stored.delete();
      collecting = 0;
      beats      = 0;
    end else if (exp_q.size() != 0) begin
      // replay in progress: input ignored
    end else if (collecting) begin
      if (iv) begin
        beats++;
        if (stored.size() < DEPTH) stored.push_back(d);
      end else begin
        collecting = 0;
        finish_burst();
      end
    end else if (iv) begin
      collecting = 1;
      stored.delete();
      stored.push_back(d);
      beats = 1;
      bmode = m;
    end

    if (exp_q.size() != 0) begin
      cur_valid  = 1;
      cur_out    = exp_q.pop_front();
      cur_ovf    = exp_ovf_q.pop_front();
      cur_result = exp_res_q.pop_front();
    end else begin
      cur_valid  = 0;
      cur_out    = 0;
      cur_ovf    = 0;
      cur_result = 0;
    end
    exp_busy = collecting || (exp_q.size() != 0);
  endtask

  task automatic tick(input bit rst, input bit iv, input int d, input int m);
    RST      = rst;
    IN_VALID = iv;
    INPUT    = DATA_W'(d);
    MODE     = 2'(m);
    @(posedge CLK);
    model_edge(rst, iv, d, m);
    #1;
    check_val("out_valid", OUT_VALID, cur_valid);
    check_val("out",       OUT,       cur_out);
    check_val("ovf",       OVF,       cur_ovf);
    check_val("busy",      BUSY,      exp_busy);
    if (OUT_VALID) seen_q.push_back(int'(OUT));
    if (cur_result) $display("result beat: out=%0d ovf=%0d busy=%0d", OUT, OVF, BUSY);
  endtask

  task automatic send_burst(input int m, input bit scramble_mode);
    for (int i = 0; i < stim_q.size(); i++) begin
      tick(0, 1, stim_q[i], (i == 0 || !scramble_mode) ? m : int'($urandom_range(0, 3)));
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((collecting || exp_q.size() != 0 || cur_valid) && i < 64) begin
      tick(0, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      i++;
    end
    if (i >= 64) check_val("drain_timeout", 1, 0);
  endtask

  task automatic check_seen(input string tag);
    check_val({tag, "_len"}, seen_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < seen_q.size(); i++) begin
      check_val(tag, seen_q[i], ref_q[i]);
    end
  endtask

  initial begin
    RST = 1; IN_VALID = 0; INPUT = '0; MODE = '0;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);

    // fwd sum
    seen_q.delete(); stim_q = '{3, 5, 7};
    send_burst(0, 0); drain();
    ref_q = '{3, 5, 7, 15}; check_seen("fwd_sum");

    // rev sum
    seen_q.delete(); stim_q = '{1, 2, 3, 4};
    send_burst(1, 0); drain();
    ref_q = '{4, 3, 2, 1, 10}; check_seen("rev_sum");

    // max / min with MODE changing mid-burst
    seen_q.delete(); stim_q = '{2, 6, 1};
    send_burst(2, 1); drain();
    ref_q = '{2, 6, 1, 6}; check_seen("max");
    seen_q.delete();
    send_burst(3, 1); drain();
    ref_q = '{2, 6, 1, 1}; check_seen("min");

    // overflow: 10 beats of 7
    seen_q.delete(); stim_q = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    send_burst(0, 0); drain();
    ref_q = '{7, 7, 7, 7, 7, 7, 7, 7, 56}; check_seen("overflow");

    // single beat, then back-to-back burst started during the result beat
    seen_q.delete(); stim_q = '{5};
    send_burst(0, 0);
    for (int i = 0; i < 16 && !cur_result; i++) tick(0, 0, 0, 0);
    if (!cur_result) check_val("result_timeout", 1, 0);
    stim_q = '{1, 1};
    send_burst(0, 0); drain();
    ref_q = '{5, 5, 1, 1, 2}; check_seen("back_to_back");

    // reset in the middle of the replay
    stim_q = '{2, 3, 4, 5};
    send_burst(0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 6, 0);
    tick(1, 0, 0, 0);
    seen_q.delete();
    repeat (5) tick(0, 0, 0, 0);
    stim_q = '{4, 4};
    send_burst(0, 0); drain();
    ref_q = '{4, 4, 8}; check_seen("after_reset");

    // random stream, including IN_VALID during replay and occasional reset
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           int'($urandom_range(0, (1 << DATA_W) - 1)),
           int'($urandom_range(0, 3)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
